// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the read side of the dual-clock FIFO.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  // Width of a counter that must represent every value 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int index_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Small register FIFO that holds words between the FIFO read port and the
// outgoing stream; head is the oldest word, count the number held.
module stream_skid_buffer
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              head,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int PTR_W = index_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_fire;
  logic             wr_fire;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_fire    = rd_en && (count_q != '0);
    wr_fire    = wr_en && ((count_q != FULL_CNT) || rd_fire);
    mem_d      = mem_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    if (clr) begin
      head_ptr_d = '0;
      tail_ptr_d = '0;
      count_d    = '0;
    end else begin
      if (wr_fire) begin
        mem_d[tail_ptr_q] = wr_data;
        tail_ptr_d        = next_ptr(tail_ptr_q);
      end
      if (rd_fire) begin
        head_ptr_d = next_ptr(head_ptr_q);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      mem_q      <= mem_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head  = mem_q[head_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the dual-clock FIFO: pops words, buffers them and
// re-presents them as a valid/ready stream framed into fixed-length packets.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int BUF_DEPTH = 2,
  parameter int PKT_LEN   = 16
) (
  input  logic                              read_clk,
  input  logic                              reset,
  input  logic                              flush,
  output logic                              fifo_read_en,
  input  logic [WIDTH-1:0]                  fifo_data_out,
  input  logic                              fifo_empty,
  output logic [WIDTH-1:0]                  m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic [count_width(BUF_DEPTH)-1:0] occupancy
);

  localparam int OCC_W  = count_width(BUF_DEPTH);
  localparam int BEAT_W = index_width(PKT_LEN);
  localparam logic [OCC_W:0]    DEPTH_LIM = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic              in_flight_q, in_flight_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              drain;
  logic              buf_wr_en;
  logic [OCC_W:0]    pending;

  // A popped word lands one cycle later; a flush in that cycle throws it away.
  assign buf_wr_en = in_flight_q && !flush;

  stream_skid_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (read_clk),
    .reset   (reset),
    .clr     (flush),
    .wr_en   (buf_wr_en),
    .wr_data (fifo_data_out),
    .rd_en   (drain),
    .head    (m_data),
    .count   (occupancy)
  );

  assign m_valid = (occupancy != '0);
  assign drain   = m_valid && m_ready;
  assign m_last  = m_valid && (beat_cnt_q == LAST_BEAT);

  // Counting the word in flight and the one leaving now keeps the buffer from
  // overflowing while still allowing a pop every cycle under full throughput.
  always_comb begin
    pending      = {1'b0, occupancy}
                 + {{OCC_W{1'b0}}, in_flight_q}
                 - {{OCC_W{1'b0}}, drain};
    fifo_read_en = reset && !fifo_empty && !flush && (pending < DEPTH_LIM);
    in_flight_d  = fifo_read_en;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      beat_cnt_d = '0;
    end else if (drain) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      in_flight_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO supplies an
// incrementing word sequence and each stream word is checked as it appears.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int WIDTH     = 32;
  localparam int BUF_DEPTH = 2;
  localparam int PKT_LEN   = 16;

  logic             read_clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             fifo_read_en;
  logic [WIDTH-1:0] fifo_data_out = '0;
  logic             fifo_empty;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [1:0]       occupancy;

  int   applied     = 0;
  int   miscompares = 0;
  int   src_wr      = 0;
  int   src_rd      = 0;
  logic gap         = 1'b0;
  int   exp_word    = 0;
  int   exp_beat    = 0;
  int   drained     = 0;
  int   pops        = 0;

  fifo_stream_reader #(
    .WIDTH     (WIDTH),
    .BUF_DEPTH (BUF_DEPTH),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .read_clk      (read_clk),
    .reset         (reset),
    .flush         (flush),
    .fifo_read_en  (fifo_read_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .occupancy     (occupancy)
  );

  always #5 read_clk = ~read_clk;

  // Word n of the source sequence has value n; gap forces artificial emptiness.
  assign fifo_empty = (src_rd >= src_wr) || gap;

  always @(posedge read_clk) begin
    if (fifo_read_en && !fifo_empty) begin
      fifo_data_out <= WIDTH'(src_rd);
      src_rd        <= src_rd + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the current stream head against the expected sequence, then
  // advances to the next cycle (negedge + 1).
  task automatic applyStimulus();
    if (fifo_read_en && !fifo_empty) pops++;
    if (m_valid) begin
      checkOutput("m_data", 64'(m_data), 64'(exp_word));
      checkOutput("m_last", 64'(m_last), 64'(exp_beat == PKT_LEN - 1));
      if (m_ready) begin
        exp_word++;
        exp_beat = (exp_beat + 1) % PKT_LEN;
        drained++;
      end
    end else begin
      checkOutput("m_last_idle", 64'(m_last), 64'(0));
    end
    @(negedge read_clk);
    #1;
  endtask

  task automatic waitDrain(input int target, input int budget);
    int n = 0;
    while (drained < target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_count", 64'(drained), 64'(target));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int target;
    int n;

    reset   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    @(negedge read_clk);
    #1;
    checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
    checkOutput("rst_read_en", 64'(fifo_read_en), 64'(0));
    checkOutput("rst_occ", 64'(occupancy), 64'(0));
    checkOutput("rst_m_last", 64'(m_last), 64'(0));
    checkOutput("rst_m_data", 64'(m_data), 64'(0));
    reset = 1'b1;
    @(negedge read_clk);
    #1;

    // Streaming: 64 words, full throughput after two cycles of latency.
    src_wr  = 64;
    m_ready = 1'b1;
    #1;
    checkOutput("lat_c0_read_en", 64'(fifo_read_en), 64'(1));
    checkOutput("lat_c0_valid", 64'(m_valid), 64'(0));
    applyStimulus();
    checkOutput("lat_c1_valid", 64'(m_valid), 64'(0));
    applyStimulus();
    checkOutput("lat_c2_valid", 64'(m_valid), 64'(1));
    checkOutput("lat_c2_data", 64'(m_data), 64'(0));
    waitDrain(64, 64);
    checkOutput("stream_end_valid", 64'(m_valid), 64'(0));
    checkOutput("stream_end_read_en", 64'(fifo_read_en), 64'(0));

    // Backpressure: buffer fills to 2 and popping stops.
    m_ready = 1'b0;
    src_wr  = src_wr + 40;
    #1;
    repeat (10) applyStimulus();
    checkOutput("bp_occ", 64'(occupancy), 64'(2));
    checkOutput("bp_read_en", 64'(fifo_read_en), 64'(0));
    checkOutput("bp_data", 64'(m_data), 64'(64));
    m_ready = 1'b1;
    #1;
    waitDrain(104, 100);
    checkOutput("bp_end_valid", 64'(m_valid), 64'(0));

    // Empty boundary: exactly three pops for three words.
    pops   = 0;
    src_wr = src_wr + 3;
    #1;
    waitDrain(107, 10);
    checkOutput("empty_valid", 64'(m_valid), 64'(0));
    checkOutput("empty_read_en", 64'(fifo_read_en), 64'(0));
    repeat (3) applyStimulus();
    checkOutput("empty_pops", 64'(pops), 64'(3));

    // Flush while one word is buffered and one is in flight.
    src_wr = src_wr + 20;
    #1;
    repeat (4) applyStimulus();
    checkOutput("pre_flush_occ", 64'(occupancy), 64'(1));
    flush   = 1'b1;
    m_ready = 1'b0;
    #1;
    checkOutput("flush_read_en", 64'(fifo_read_en), 64'(0));
    applyStimulus();
    flush   = 1'b0;
    m_ready = 1'b1;
    #1;
    checkOutput("flush_occ", 64'(occupancy), 64'(0));
    checkOutput("flush_valid", 64'(m_valid), 64'(0));
    exp_word = src_rd;
    exp_beat = 0;
    target   = drained + (src_wr - src_rd);
    applyStimulus();
    checkOutput("flush_c2_valid", 64'(m_valid), 64'(0));
    waitDrain(target, 40);

    // Asynchronous reset in the middle of a transfer.
    src_wr = src_wr + 30;
    #1;
    repeat (6) applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("rstmid_valid", 64'(m_valid), 64'(0));
    checkOutput("rstmid_read_en", 64'(fifo_read_en), 64'(0));
    checkOutput("rstmid_occ", 64'(occupancy), 64'(0));
    checkOutput("rstmid_last", 64'(m_last), 64'(0));
    applyStimulus();
    applyStimulus();
    reset = 1'b1;
    #1;
    exp_word = src_rd;
    exp_beat = 0;
    target   = drained + (src_wr - src_rd);
    waitDrain(target, 60);

    // Random ready and FIFO gaps over 10k words.
    target = drained + 10000;
    src_wr = src_wr + 10000;
    n      = 0;
    while (drained < target && n < 60000) begin
      m_ready = 1'($urandom_range(0, 1));
      gap     = ($urandom_range(0, 3) == 0);
      #1;
      checkOutput("rand_occ_bound", 64'(occupancy <= 2'd2), 64'(1));
      applyStimulus();
      n++;
    end
    gap = 1'b0;
    checkOutput("rand_drain_count", 64'(drained), 64'(target));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
